pc_fetch_stage: RTL and testbench

Fetch stage sitting directly downstream of the PC next-address multiplexer. It holds the program counter, presents it to instruction memory, produces PC+4 for the sequential-address adder path, and captures the fetched instruction plus its PC+4 into the IF/ID pipeline register. It also implements stall, flush, start, single-step and halt control for the debug unit, and keeps a cycle counter.

---
 rtl/pc_fetch_stage.sv | 139 +++++++++++++
 tb/tb_pc_fetch_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage
//   Instruction fetch stage: holds the program counter, presents it to
//   instruction memory, provides PC+4 to the next-address mux, and captures
//   the fetched instruction with its PC+4 into the IF/ID register. Debug
//   control (start, single-step, halt) gates all advancement, and a saturating
//   counter tracks cycles in which the stage was allowed to advance.
//
// Ports
//   i_clk          clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_Start        leave IDLE and begin execution
//   i_StepMode     1 = advance only on i_Step
//   i_Step         single-cycle advance request
//   i_Stall        hold PC and IF/ID
//   i_Flush        zero IF/ID (NOP)
//   i_NextPC       next PC from the PC multiplexer
//   i_Instr        instruction memory read data for o_PC
//   o_PC           current PC
//   o_PC4          o_PC + 4 (combinational, wraps)
//   o_IFID_Instr   registered instruction to decode
//   o_IFID_PC4     registered PC+4 of that instruction
//   o_Running      state is RUN
//   o_Halted       state is HALT
//   o_CycleCount   saturating count of advance-enabled cycles
module pc_fetch_stage #(
  parameter int unsigned      NBITS       = 32,
  parameter logic [NBITS-1:0] PC_RESET    = '0,
  parameter logic [5:0]       HALT_OPCODE = 6'b111111
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_Start,
  input  logic             i_StepMode,
  input  logic             i_Step,
  input  logic             i_Stall,
  input  logic             i_Flush,
  input  logic [NBITS-1:0] i_NextPC,
  input  logic [NBITS-1:0] i_Instr,
  output logic [NBITS-1:0] o_PC,
  output logic [NBITS-1:0] o_PC4,
  output logic [NBITS-1:0] o_IFID_Instr,
  output logic [NBITS-1:0] o_IFID_PC4,
  output logic             o_Running,
  output logic             o_Halted,
  output logic [NBITS-1:0] o_CycleCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic advance;
  logic load_instr;
  logic halt_hit;
  logic load_pc;

  assign o_PC4 = o_PC + NBITS'(4);

  // Advance gate: running, and either free-running or a step is requested.
  assign advance    = (state == RUN) && (!i_StepMode || i_Step);
  assign load_instr = advance && !i_Flush && !i_Stall;
  assign halt_hit   = load_instr && (i_Instr[31:26] == HALT_OPCODE);
  // On the halt edge the PC stays parked on the halt instruction's address.
  assign load_pc    = advance && !i_Stall && !halt_hit;

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (i_Start) state_next = RUN;
      RUN:     if (halt_hit) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    o_Running = 1'b0;
    o_Halted  = 1'b0;
    unique case (state)
      RUN:     o_Running = 1'b1;
      HALT:    o_Halted  = 1'b1;
      default: ;
    endcase
  end

  // Program counter
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_PC <= PC_RESET;
    end else if (load_pc) begin
      o_PC <= i_NextPC;
    end
  end

  // IF/ID register: drains with NOPs once halted; flush beats stall.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_IFID_Instr <= '0;
      o_IFID_PC4   <= '0;
    end else if (state == HALT) begin
      o_IFID_Instr <= '0;
      o_IFID_PC4   <= '0;
    end else if (advance) begin
      if (i_Flush) begin
        o_IFID_Instr <= '0;
        o_IFID_PC4   <= '0;
      end else if (!i_Stall) begin
        o_IFID_Instr <= i_Instr;
        o_IFID_PC4   <= o_PC4;
      end
    end
  end

  // Cycle counter: counts every enabled cycle, including stalls and flushes.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_CycleCount <= '0;
    end else if (advance && (o_CycleCount != '1)) begin
      o_CycleCount <= o_CycleCount + NBITS'(1);
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
module tb_pc_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        start, step_mode, step, stall, flush;
  logic [31:0] next_pc, instr;
  logic [31:0] pc, pc4, ifid_instr, ifid_pc4, cycle_count;
  logic        running, halted;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pc_fetch_stage #(
    .NBITS(32),
    .PC_RESET(32'h0),
    .HALT_OPCODE(6'b111111)
  ) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_Start(start),
    .i_StepMode(step_mode),
    .i_Step(step),
    .i_Stall(stall),
    .i_Flush(flush),
    .i_NextPC(next_pc),
    .i_Instr(instr),
    .o_PC(pc),
    .o_PC4(pc4),
    .o_IFID_Instr(ifid_instr),
    .o_IFID_PC4(ifid_pc4),
    .o_Running(running),
    .o_Halted(halted),
    .o_CycleCount(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        step_mode;
    logic        step;
    logic        stall;
    logic        flush;
    logic [31:0] next_pc;
    logic [31:0] instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_ifid_instr;
    logic [31:0] exp_ifid_pc4;
    logic        exp_running;
    logic        exp_halted;
    logic [31:0] exp_count;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ii,
                           input logic [31:0] e_ip, input logic e_run, input logic e_halt,
                           input logic [31:0] e_cnt);
    check({tag, " pc"}, pc, e_pc);
    check({tag, " pc4"}, pc4, e_pc + 32'd4);
    check({tag, " ifid_instr"}, ifid_instr, e_ii);
    check({tag, " ifid_pc4"}, ifid_pc4, e_ip);
    check({tag, " running"}, {31'd0, running}, {31'd0, e_run});
    check({tag, " halted"}, {31'd0, halted}, {31'd0, e_halt});
    check({tag, " count"}, cycle_count, e_cnt);
  endtask

  task automatic add(input logic s, input logic m, input logic t, input logic st, input logic f,
                     input logic [31:0] np, input logic [31:0] in,
                     input logic [31:0] e_pc, input logic [31:0] e_ii, input logic [31:0] e_ip,
                     input logic e_run, input logic e_halt, input logic [31:0] e_cnt);
    vec_t v;
    v = '{s, m, t, st, f, np, in, e_pc, e_ii, e_ip, e_run, e_halt, e_cnt};
    tv.push_back(v);
  endtask

  task automatic drive_idle();
    start = 0; step_mode = 0; step = 0; stall = 0; flush = 0;
    next_pc = '0; instr = '0;
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;

    //  s m t st f  next_pc       instr          pc        ifid_instr    ifid_pc4  run halt cnt
    add(0,0,0,0,0, 32'h80,       32'hAAAAAAAA,  32'h0,    32'h0,        32'h0,    0,0, 0);  // IDLE holds
    add(1,0,0,0,0, 32'h80,       32'hAAAAAAAA,  32'h0,    32'h0,        32'h0,    1,0, 0);  // start edge
    add(0,0,0,0,0, 32'h4,        32'h11111111,  32'h4,    32'h11111111, 32'h4,    1,0, 1);
    add(0,0,0,0,0, 32'h8,        32'h22222222,  32'h8,    32'h22222222, 32'h8,    1,0, 2);
    add(0,0,0,1,0, 32'h99,       32'hDEAD0000,  32'h8,    32'h22222222, 32'h8,    1,0, 3);  // stall
    add(0,0,0,1,0, 32'h99,       32'hDEAD0000,  32'h8,    32'h22222222, 32'h8,    1,0, 4);
    add(0,0,0,0,0, 32'hC,        32'h33333333,  32'hC,    32'h33333333, 32'hC,    1,0, 5);
    add(0,0,0,0,0, 32'h10,       32'h44444444,  32'h10,   32'h44444444, 32'h10,   1,0, 6);
    add(0,0,0,1,1, 32'h40,       32'h55555555,  32'h10,   32'h0,        32'h0,    1,0, 7);  // flush+stall
    add(0,0,0,0,1, 32'h40,       32'h55555555,  32'h40,   32'h0,        32'h0,    1,0, 8);  // flush
    for (int i = 0; i < 4; i++)
      add(0,1,0,0,0, 32'h44,     32'h66666666,  32'h40,   32'h0,        32'h0,    1,0, 8);
    add(0,1,1,0,0, 32'h44,       32'h66666666,  32'h44,   32'h66666666, 32'h44,   1,0, 9);
    for (int i = 0; i < 4; i++)
      add(0,1,0,0,0, 32'h48,     32'h67676767,  32'h44,   32'h66666666, 32'h44,   1,0, 9);
    add(0,1,1,0,0, 32'h48,       32'h67676767,  32'h48,   32'h67676767, 32'h48,   1,0, 10);
    for (int i = 0; i < 4; i++)
      add(0,1,0,0,0, 32'h4C,     32'h68686868,  32'h48,   32'h67676767, 32'h48,   1,0, 10);
    add(0,1,1,0,0, 32'h4C,       32'h68686868,  32'h4C,   32'h68686868, 32'h4C,   1,0, 11);
    add(0,1,1,0,0, 32'h50,       32'h69696969,  32'h50,   32'h69696969, 32'h50,   1,0, 12); // step held
    add(0,0,0,0,0, 32'h20,       32'h00000013,  32'h20,   32'h00000013, 32'h54,   1,0, 13);
    add(0,0,0,0,0, 32'h24,       32'hFC000000,  32'h20,   32'hFC000000, 32'h24,   0,1, 14); // halt
    add(1,0,0,0,0, 32'h30,       32'h12345678,  32'h20,   32'h0,        32'h0,    0,1, 14);
    add(1,0,1,0,0, 32'h34,       32'h00000001,  32'h20,   32'h0,        32'h0,    0,1, 14);

    #3;
    check_all("reset", 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      start = tv[i].start; step_mode = tv[i].step_mode; step = tv[i].step;
      stall = tv[i].stall; flush = tv[i].flush;
      next_pc = tv[i].next_pc; instr = tv[i].instr;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), tv[i].exp_pc, tv[i].exp_ifid_instr, tv[i].exp_ifid_pc4,
                tv[i].exp_running, tv[i].exp_halted, tv[i].exp_count);
    end

    // Leave HALT via reset, run to PC=0x1C, then reset between edges.
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    #1;
    check_all("halt_reset", 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 0; next_pc = 32'h1C; instr = 32'h0BADF00D;
    @(posedge clk); #1;
    check_all("to_1c", 32'h1C, 32'h0BADF00D, 32'h4, 1, 0, 32'd1);
    @(negedge clk);
    next_pc = 32'h20;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
    @(posedge clk); #1;
    check("reset_held pc", pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("post_reset_idle", 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);

    // PC wrap: o_PC4 of 0xFFFFFFFC is 0.
    @(negedge clk);
    start = 1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 0; next_pc = 32'hFFFFFFFC; instr = 32'h00000001;
    @(posedge clk); #1;
    check_all("wrap_load", 32'hFFFFFFFC, 32'h00000001, 32'h4, 1, 0, 32'd1);
    check("wrap pc4_zero", pc4, 32'h0);
    @(negedge clk);
    next_pc = pc4; instr = 32'h00000002;
    @(posedge clk); #1;
    check_all("wrap_next", 32'h0, 32'h00000002, 32'h0, 1, 0, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
